// File: rtl/alu_operand_stage_pkg.sv
// rtl/alu_operand_stage_pkg.sv - shared opcodes, widths and write-back decode for the ALU operand stage
package alu_operand_stage_pkg;

    localparam int DEFAULT_BITS     = 16;
    localparam int DEFAULT_REG_BITS = 4;
    localparam int DEFAULT_IMM_BITS = 4;
    localparam int ALU_OP_BITS      = 5;

    typedef enum logic [ALU_OP_BITS-1:0] {
        OP_MOV           = 5'd0,
        OP_ADD           = 5'd1,
        OP_SUB           = 5'd2,
        OP_AND           = 5'd3,
        OP_OR            = 5'd4,
        OP_XOR           = 5'd5,
        OP_NOT           = 5'd6,
        OP_SHL           = 5'd7,
        OP_SHR           = 5'd8,
        OP_SAR           = 5'd9,
        OP_ROL           = 5'd10,
        OP_ROR           = 5'd11,
        OP_CMP           = 5'd12,
        OP_TEST          = 5'd13,
        OP_ADC           = 5'd14,
        OP_SBC           = 5'd15,
        OP_NEG           = 5'd16,
        OP_INC           = 5'd17,
        OP_DEC           = 5'd18,
        OP_MUL           = 5'd19,
        OP_SWAP          = 5'd20,
        OP_SEXT          = 5'd21,
        OP_ZEXT          = 5'd22,
        OP_JMP           = 5'd23,
        OP_JZ            = 5'd24,
        OP_JNZ           = 5'd25,
        OP_JC            = 5'd26,
        OP_JNC           = 5'd27,
        OP_STORE         = 5'd28,
        OP_GET_FLAGS     = 5'd29,
        OP_RESTORE_FLAGS = 5'd30,
        OP_NOP           = 5'd31
    } alu_op_e;

    // Flag-only, control-flow and store ops leave the register file untouched.
    function automatic logic writes_reg(input logic [ALU_OP_BITS-1:0] op);
        logic result;
        result = 1'b1;
        case (op)
            OP_CMP, OP_TEST, OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_JNC,
            OP_STORE, OP_RESTORE_FLAGS, OP_NOP: result = 1'b0;
            default: result = 1'b1;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/alu_operand_stage_operand_bypass_mux.sv
// rtl/alu_operand_stage_operand_bypass_mux.sv - operand select: r0/rf/wb/imm at issue, alu_result/latched in execute
module operand_bypass_mux
    import alu_operand_stage_pkg::*;
#(
    parameter int BITS     = DEFAULT_BITS,
    parameter int REG_BITS = DEFAULT_REG_BITS
) (
    input  logic [REG_BITS-1:0] src,
    input  logic [BITS-1:0]     rfData,
    input  logic                useImm,
    input  logic [BITS-1:0]     immValue,
    input  logic                wbActive,
    input  logic [REG_BITS-1:0] wbAddr,
    input  logic [BITS-1:0]     wbData,
    input  logic                fwd,
    input  logic [BITS-1:0]     latched,
    input  logic [BITS-1:0]     aluResult,
    output logic [BITS-1:0]     dOperand,
    output logic [BITS-1:0]     eOperand
);

    always_comb begin
        dOperand = rfData;
        if (useImm) begin
            dOperand = immValue;
        end else if (src == '0) begin
            dOperand = '0;
        end else if (wbActive && (wbAddr == src)) begin
            dOperand = wbData;
        end
    end

    assign eOperand = fwd ? aluResult : latched;

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - issue/operand stage feeding the ALU with prefix immediates and two bypass paths
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int BITS     = DEFAULT_BITS,
    parameter int REG_BITS = DEFAULT_REG_BITS,
    parameter int IMM_BITS = DEFAULT_IMM_BITS
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic                     stall,
    input  logic                     is_prefix,
    input  logic [BITS-IMM_BITS-1:0] prefix_in,
    input  logic [ALU_OP_BITS-1:0]   alu_op_in,
    input  logic [REG_BITS-1:0]      dest_in,
    input  logic [REG_BITS-1:0]      srcA_in,
    input  logic [REG_BITS-1:0]      srcB_in,
    input  logic                     use_imm,
    input  logic [IMM_BITS-1:0]      imm_in,
    output logic [REG_BITS-1:0]      rfA_addr,
    input  logic [BITS-1:0]          rfA_data,
    output logic [REG_BITS-1:0]      rfB_addr,
    input  logic [BITS-1:0]          rfB_data,
    output logic [BITS-1:0]          A,
    output logic [BITS-1:0]          B,
    output logic [ALU_OP_BITS-1:0]   aluOp,
    output logic                     execute,
    input  logic [BITS-1:0]          alu_result,
    output logic                     wb_we,
    output logic [REG_BITS-1:0]      wb_addr,
    output logic [BITS-1:0]          wb_data
);

    logic                     accept;
    logic                     aluAccept;
    logic                     prefixAccept;
    logic [BITS-IMM_BITS-1:0] prefixReg;
    logic                     prefixValid;
    logic [BITS-1:0]          immValue;
    logic                     exValid;
    logic                     exWrites;
    logic [ALU_OP_BITS-1:0]   exOp;
    logic [REG_BITS-1:0]      exDest;
    logic [BITS-1:0]          latchA;
    logic [BITS-1:0]          latchB;
    logic                     fwdA;
    logic                     fwdB;
    logic                     hitA;
    logic                     hitB;
    logic                     wbWe;
    logic [REG_BITS-1:0]      wbAddr;
    logic [BITS-1:0]          dOperandA;
    logic [BITS-1:0]          dOperandB;

    assign instr_ready  = !stall;
    assign accept       = instr_valid && !stall && !RST;
    assign aluAccept    = accept && !is_prefix;
    assign prefixAccept = accept && is_prefix;

    assign rfA_addr = srcA_in;
    assign rfB_addr = srcB_in;

    assign immValue = prefixValid ? {prefixReg, imm_in}
                                  : {{(BITS-IMM_BITS){1'b0}}, imm_in};

    // The instruction now in E produces its result on alu_result next cycle.
    assign hitA = exValid && exWrites && (exDest == srcA_in) && (srcA_in != '0);
    assign hitB = exValid && exWrites && (exDest == srcB_in) && (srcB_in != '0) && !use_imm;

    operand_bypass_mux #(
        .BITS     (BITS),
        .REG_BITS (REG_BITS)
    ) muxA (
        .src       (srcA_in),
        .rfData    (rfA_data),
        .useImm    (1'b0),
        .immValue  ({BITS{1'b0}}),
        .wbActive  (wbWe),
        .wbAddr    (wbAddr),
        .wbData    (alu_result),
        .fwd       (fwdA),
        .latched   (latchA),
        .aluResult (alu_result),
        .dOperand  (dOperandA),
        .eOperand  (A)
    );

    operand_bypass_mux #(
        .BITS     (BITS),
        .REG_BITS (REG_BITS)
    ) muxB (
        .src       (srcB_in),
        .rfData    (rfB_data),
        .useImm    (use_imm),
        .immValue  (immValue),
        .wbActive  (wbWe),
        .wbAddr    (wbAddr),
        .wbData    (alu_result),
        .fwd       (fwdB),
        .latched   (latchB),
        .aluResult (alu_result),
        .dOperand  (dOperandB),
        .eOperand  (B)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            prefixReg   <= '0;
            prefixValid <= 1'b0;
            exValid     <= 1'b0;
            exWrites    <= 1'b0;
            exOp        <= '0;
            exDest      <= '0;
            latchA      <= '0;
            latchB      <= '0;
            fwdA        <= 1'b0;
            fwdB        <= 1'b0;
            wbWe        <= 1'b0;
            wbAddr      <= '0;
        end else begin
            exValid <= aluAccept;
            wbWe    <= exValid && exWrites;
            wbAddr  <= exDest;
            if (prefixAccept) begin
                prefixReg   <= prefix_in;
                prefixValid <= 1'b1;
            end
            if (aluAccept) begin
                prefixValid <= 1'b0;
                exOp        <= alu_op_in;
                exDest      <= dest_in;
                exWrites    <= writes_reg(alu_op_in) && (dest_in != '0);
                latchA      <= dOperandA;
                latchB      <= dOperandB;
                fwdA        <= hitA;
                fwdB        <= hitB;
            end
        end
    end

    assign aluOp   = exOp;
    assign execute = exValid;
    assign wb_we   = wbWe;
    assign wb_addr = wbAddr;
    assign wb_data = alu_result;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - scoreboard bench with architectural register model, external rf and ALU
module tb_alu_operand_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        instr_valid;
    logic        instr_ready;
    logic        stall;
    logic        is_prefix;
    logic [11:0] prefix_in;
    logic [4:0]  alu_op_in;
    logic [3:0]  dest_in;
    logic [3:0]  srcA_in;
    logic [3:0]  srcB_in;
    logic        use_imm;
    logic [3:0]  imm_in;
    logic [3:0]  rfA_addr;
    logic [15:0] rfA_data;
    logic [3:0]  rfB_addr;
    logic [15:0] rfB_data;
    logic [15:0] A;
    logic [15:0] B;
    logic [4:0]  aluOp;
    logic        execute;
    logic [15:0] alu_result;
    logic        wb_we;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;

    alu_operand_stage dut (
        .CLK         (CLK),
        .RST         (RST),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .stall       (stall),
        .is_prefix   (is_prefix),
        .prefix_in   (prefix_in),
        .alu_op_in   (alu_op_in),
        .dest_in     (dest_in),
        .srcA_in     (srcA_in),
        .srcB_in     (srcB_in),
        .use_imm     (use_imm),
        .imm_in      (imm_in),
        .rfA_addr    (rfA_addr),
        .rfA_data    (rfA_data),
        .rfB_addr    (rfB_addr),
        .rfB_data    (rfB_data),
        .A           (A),
        .B           (B),
        .aluOp       (aluOp),
        .execute     (execute),
        .alu_result  (alu_result),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    logic [15:0] initVals [16];
    logic [15:0] rf [16];
    logic [15:0] refRegs [16];
    logic        pv = 1'b0;
    logic [11:0] pfx = '0;
    logic        rstQ;
    logic [36:0] eq [$];
    logic [19:0] wq [$];

    function automatic logic [15:0] aluf(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            5'd0:    return b;
            5'd1:    return a + b;
            5'd2:    return a - b;
            5'd3:    return a & b;
            5'd4:    return a | b;
            5'd5:    return a ^ b;
            default: return a + b + {11'd0, op};
        endcase
    endfunction

    function automatic logic modelWrites(input logic [4:0] op);
        return !(op inside {5'd12, 5'd13, [5'd23:5'd28], 5'd30, 5'd31});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    assign rfA_data = rf[rfA_addr];
    assign rfB_data = rf[rfB_addr];

    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) rf[i] <= initVals[i];
        end else if (wb_we && wb_addr != 4'd0) begin
            rf[wb_addr] <= wb_data;
        end
    end

    always @(posedge CLK) begin
        if (RST) alu_result <= '0;
        else if (execute) alu_result <= aluf(aluOp, A, B);
    end

    always @(posedge CLK) rstQ <= RST;

    initial begin
        logic [36:0] e;
        logic [19:0] w;
        forever begin
            @(negedge CLK);
            chk("instr_ready", {31'd0, instr_ready}, {31'd0, !stall});
            if (rstQ === 1'b1) begin
                chk("rst_execute", {31'd0, execute}, 0);
                chk("rst_wb_we", {31'd0, wb_we}, 0);
                chk("rst_A", {16'd0, A}, 0);
                chk("rst_B", {16'd0, B}, 0);
                chk("rst_aluOp", {27'd0, aluOp}, 0);
                chk("rst_wb_addr", {28'd0, wb_addr}, 0);
            end else if (rstQ === 1'b0) begin
                if (execute) begin
                    if (eq.size() == 0) begin
                        chk("unexpected_execute", 1, 0);
                    end else begin
                        e = eq.pop_front();
                        chk("E_A", {16'd0, A}, {16'd0, e[36:21]});
                        chk("E_B", {16'd0, B}, {16'd0, e[20:5]});
                        chk("E_aluOp", {27'd0, aluOp}, {27'd0, e[4:0]});
                    end
                end
                if (wb_we) begin
                    if (wq.size() == 0) begin
                        chk("unexpected_wb_we", 1, 0);
                    end else begin
                        w = wq.pop_front();
                        chk("W_addr", {28'd0, wb_addr}, {28'd0, w[19:16]});
                        chk("W_data", {16'd0, wb_data}, {16'd0, w[15:0]});
                    end
                end
            end
        end
    end

    // Sequential ISA semantics: each accepted instruction sees all earlier results.
    task automatic modelIssue(input logic pf, input logic [11:0] px, input logic [4:0] op,
                              input logic [3:0] d, input logic [3:0] sa, input logic [3:0] sb,
                              input logic ui, input logic [3:0] im);
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        if (pf) begin
            pv  = 1'b1;
            pfx = px;
        end else begin
            a = (sa == 4'd0) ? 16'd0 : refRegs[sa];
            if (ui) b = pv ? {pfx, im} : {12'd0, im};
            else    b = (sb == 4'd0) ? 16'd0 : refRegs[sb];
            pv = 1'b0;
            eq.push_back({a, b, op});
            r = aluf(op, a, b);
            if (modelWrites(op) && d != 4'd0) begin
                refRegs[d] = r;
                wq.push_back({d, r});
            end
        end
    endtask

    task automatic drive(input logic v, input logic st, input logic pf, input logic [11:0] px,
                         input logic [4:0] op, input logic [3:0] d, input logic [3:0] sa,
                         input logic [3:0] sb, input logic ui, input logic [3:0] im);
        instr_valid = v;
        stall       = st;
        is_prefix   = pf;
        prefix_in   = px;
        alu_op_in   = op;
        dest_in     = d;
        srcA_in     = sa;
        srcB_in     = sb;
        use_imm     = ui;
        imm_in      = im;
        if (v && !st && !RST) modelIssue(pf, px, op, d, sa, sb, ui, im);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 12'h0, 5'd0, 4'd0, 4'd0, 4'd0, 0, 4'd0);
    endtask

    task automatic alu(input logic [4:0] op, input logic [3:0] d, input logic [3:0] sa, input logic [3:0] sb);
        drive(1, 0, 0, 12'h0, op, d, sa, sb, 0, 4'd0);
    endtask

    task automatic aluImm(input logic [4:0] op, input logic [3:0] d, input logic [3:0] sa, input logic [3:0] im);
        drive(1, 0, 0, 12'h0, op, d, sa, 4'd0, 1, im);
    endtask

    task automatic prefix(input logic [11:0] px);
        drive(1, 0, 1, px, 5'd0, 4'd0, 4'd0, 4'd0, 0, 4'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) initVals[i] = 16'($urandom);
        initVals[0] = 16'hDEAD;
        initVals[1] = 16'h0003;
        initVals[2] = 16'h0004;
        for (int i = 0; i < 16; i++) refRegs[i] = initVals[i];
        refRegs[0] = 16'h0000;

        RST = 1'b1;
        drive(1, 0, 0, 12'h0, 5'd1, 4'd5, 4'd1, 4'd2, 0, 4'd0);
        drive(1, 0, 0, 12'h0, 5'd1, 4'd5, 4'd1, 4'd2, 0, 4'd0);
        RST = 1'b0;
        idle(2);

        alu(5'd1, 4'd3, 4'd1, 4'd2);
        idle(3);
        chk("rf_r3_add", {16'd0, rf[3]}, 32'h0007);

        alu(5'd1, 4'd3, 4'd1, 4'd2);
        alu(5'd1, 4'd4, 4'd3, 4'd1);
        idle(3);
        chk("rf_r4_b2b", {16'd0, rf[4]}, 32'h000A);

        alu(5'd2, 4'd3, 4'd3, 4'd1);
        alu(5'd1, 4'd3, 4'd1, 4'd2);
        alu(5'd0, 4'd5, 4'd0, 4'd6);
        alu(5'd5, 4'd7, 4'd3, 4'd3);
        idle(3);
        chk("rf_r7_dist2", {16'd0, rf[7]}, 32'h0000);

        prefix(12'h123);
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 12'h0, 5'd1, 4'd6, 4'd0, 4'd0, 1, 4'h9);
        aluImm(5'd1, 4'd1, 4'd0, 4'h4);
        aluImm(5'd1, 4'd9, 4'd0, 4'h4);
        prefix(12'h111);
        prefix(12'h222);
        aluImm(5'd1, 4'd10, 4'd0, 4'h5);
        idle(3);
        chk("rf_r1_prefix", {16'd0, rf[1]}, 32'h1234);
        chk("rf_r9_noprefix", {16'd0, rf[9]}, 32'h0004);
        chk("rf_r10_lastprefix", {16'd0, rf[10]}, 32'h2225);

        alu(5'd12, 4'd1, 4'd1, 4'd2);
        alu(5'd1, 4'd0, 4'd1, 4'd2);
        alu(5'd1, 4'd8, 4'd0, 4'd1);
        idle(3);
        chk("rf_r8_r0src", {16'd0, rf[8]}, 32'h1234);
        chk("rf_r1_after_cmp", {16'd0, rf[1]}, 32'h1234);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
                  12'($urandom), 5'($urandom_range(0, 31)), 4'($urandom_range(0, 7)),
                  4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                  $urandom_range(0, 9) < 3, 4'($urandom));
        end
        idle(4);

        chk("eq_drained", eq.size(), 0);
        chk("wq_drained", wq.size(), 0);
        for (int i = 1; i < 16; i++) chk($sformatf("rf_final_r%0d", i), {16'd0, rf[i]}, {16'd0, refRegs[i]});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Issue/operand stage directly upstream of the ALU.
- Accepts decoded ALU instructions and reads two register-file ports. Builds the A/B operands, including the immediate-prefix extension, and drives aluOp/execute into the ALU.
- Tracks each in-flight destination so the ALU's registered result is written back one cycle after execute.
- Resolves read-after-write hazards with two bypass paths, so back-to-back dependent instructions never stall.

Parameters:
- BITS, 16, datapath width (matches ALU).
- REG_BITS, 4, register address width (16 registers; r0 reads as zero, writes to r0 discarded).
- IMM_BITS, 4, short immediate width carried in the instruction.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- instr_valid  in  1  decoded instruction present.
- instr_ready  out  1  stage can accept; equals !stall.
- stall  in  1  upstream/global hold; blocks acceptance only.
- is_prefix  in  1  instruction is an IMM prefix, not an ALU op.
- prefix_in  in  BITS-IMM_BITS  upper immediate bits carried by a prefix.
- alu_op_in  in  5  ALU operation code.
- dest_in  in  REG_BITS  destination register.
- srcA_in  in  REG_BITS  A source register.
- srcB_in  in  REG_BITS  B source register.
- use_imm  in  1  B comes from the immediate, not srcB.
- imm_in  in  IMM_BITS  short immediate.
- rfA_addr  out  REG_BITS  register file read address A (combinational read).
- rfA_data  in  BITS  register file read data A.
- rfB_addr  out  REG_BITS  register file read address B.
- rfB_data  in  BITS  register file read data B.
- A  out  BITS  ALU operand A.
- B  out  BITS  ALU operand B.
- aluOp  out  5  ALU operation.
- execute  out  1  ALU execute strobe.
- alu_result  in  BITS  ALU registered output (aluOut).
- wb_we  out  1  register file write enable.
- wb_addr  out  REG_BITS  write address.
- wb_data  out  BITS  write data; equals alu_result.

Behaviour:
- Pipeline: D (accept, cycle n) -> E (execute=1, cycle n+1) -> W (wb_we=1, cycle n+2).
- E and W always advance every cycle; stall only inserts bubbles (execute=0) into E.
- Accept condition: instr_valid && !stall.
  - A prefix instruction is consumed without creating an E slot.
- Prefix register:
  - An accepted prefix loads prefix_in and sets prefix_valid.
  - A second prefix overwrites the first.
  - The next accepted ALU instruction consumes and clears prefix_valid.
  - prefix_valid persists across stall cycles.
- Immediate B:
  - With prefix_valid: B = {prefix, imm_in}.
  - Without prefix_valid: B = zero-extended imm_in.
- Writes-back decode, registered into E/W:
  - Writing ops: 0–11, 14–22, 29.
  - Non-writing ops: 12 (cmp), 13 (test), 23–28, 30, 31.
  - dest 0 never writes.
- D-stage bypass: if W is active and wb_addr == src != 0, the latched operand takes wb_data instead of rf data.
- E-stage bypass: at accept, fwdA/fwdB are registered as (E writes && E.dest == src && src != 0).
  - In E, A/B output alu_result when the flag is set; otherwise the latched operand.
  - An immediate B never forwards.
- Priority: E-stage bypass over D-stage bypass over register file. Source r0 always yields 0.
- Bubble cycle: execute=0. A, B and aluOp hold their last values (don't care).
- W occurs exactly when the prior cycle had execute=1 with a writing op.
- Simultaneous prefix accept while an instruction sits in E/W: no interaction.
- Reset:
  - execute=0, wb_we=0, A=B=0, aluOp=0, wb_addr=0, prefix_valid=0, fwd flags=0.
  - In-flight E/W instructions are dropped with no write.
  - instr_ready follows stall during reset but nothing is accepted while RST=1.

Decomposition:
- Shared package holds:
  - ALU opcode constants (OP_MOV=0 … OP_RESTORE_FLAGS=30).
  - A writes_reg(op) function.
  - BITS and REG_BITS defaults.
- Sub-module operand_bypass_mux, instantiated twice (A and B): selects r0/rf/wb/imm at D and alu_result/latched at E.
- Register file stays external.

Test Plan:
- Reset: RST=1 for 2 cycles with instr_valid=1 -> execute=0, wb_we=0 throughout; no write after release.
- Independent op: rf r1=0x0003, r2=0x0004, add r3,r1,r2 accepted at cycle 0 -> execute=1 with A=3, B=4, aluOp=1 at cycle 1; wb_we=1, wb_addr=3, wb_data=0x0007 at cycle 2.
- Back-to-back dependency: add r3,r1,r2 then add r4,r3,r1 -> second E has A=alu_result=0x0007; r4 written 0x000A.
- Distance-2 dependency: add r3; mov r5,r6; xor r7,r3,r3 -> xor latches r3 via wb bypass (0x0007) while rf still holds stale value.
- Prefix: prefix 0x123, stall 3 cycles, add r1,r0,#0x4 -> B=0x1234; the following #0x4 instruction gets B=0x0004. Two consecutive prefixes -> last one wins.
- Non-writing ops and r0: cmp r1,r2 then add r0,r1,r2 -> no wb_we for either; a following read of r0 yields 0, with no forward.
